alu_op_issuer: RTL and testbench
================================

// Module: alu_op_issuer
// PURPOSE
//  Command-side driver for the packed 8-bit ALU operation port: op word = {sel[2:0], A[2:0], B[1:0]}.
//  - Accepts operations over a valid/ready handshake and buffers them in a small FIFO.
//  - Drives one packed op word at a time and holds it stable for SETTLE cycles.
//  - Captures the 8-bit ALU result and presents it with the op's sel as a tag over valid/ready.
//  - Sits between the control logic and the ALU wrapper. It is the producer of that wrapper's input byte and the consumer of its output byte.
// PARAMETERS
//  DEPTH   4   command FIFO entries; power of 2, >=2
//  SETTLE  1   cycles op_word is held stable before alu_result is sampled; >=1
// PORTS
//  clk         in   1  single clock, rising edge
//  rst         in   1  asynchronous, active-high reset
//  cmd_valid   in   1  command offered
//  cmd_ready   out  1  command accepted when cmd_valid&cmd_ready at a clk edge
//  cmd_sel     in   3  operation select
//  cmd_a       in   3  operand A
//  cmd_b       in   2  operand B
//  op_word     out  8  {sel,A,B} driven to ALU input byte
//  alu_result  in   8  ALU output byte (combinational from op_word)
//  res_valid   out  1  result available
//  res_ready   in   1  result consumed when res_valid&res_ready at a clk edge
//  res_data    out  8  captured alu_result
//  res_tag     out  3  sel of the op that produced res_data
//  busy        out  1  FSM not IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (async assert, sync to clk on release):
//  - All outputs reset to 0, cmd_ready included. FIFO emptied, FSM=IDLE.
//  - cmd_ready rises on the first edge after release.
//  FIFO:
//  - cmd_ready = !full; it is registered-state derived, never combinational from cmd_valid.
//  - No push when full, even if a pop occurs in the same cycle.
//  - Push and pop in the same cycle when not full: count is unchanged.
//  - Pointers wrap modulo DEPTH.
//  - No bypass: a command pushed at edge k can pop at edge k+1 at the earliest.
//  FSM (states IDLE, WAIT, HOLD):
//  - IDLE: if FIFO non-empty, pop and register op_word<={sel,a,b}, tag<=sel, cnt<=SETTLE-1, go WAIT. Otherwise stay.
//  - WAIT: if cnt==0, res_data<=alu_result, res_tag<=tag, res_valid<=1, go HOLD. Otherwise cnt<=cnt-1.
//  - HOLD: res_data/res_tag stable while res_valid=1.
//    - On res_ready: res_valid<=0. If FIFO non-empty, pop in the same edge (load as in IDLE) and go WAIT; otherwise go IDLE.
//    - Without res_ready: stay (backpressure). The FIFO keeps filling.
//  - op_word holds its last value between ops; it changes only on a pop.
//  Latency and throughput:
//  - Accept at edge k -> op_word at k+1 -> res_valid at k+1+SETTLE (empty FIFO, IDLE).
//  - Steady-state throughput with res_ready=1: one result per SETTLE+1 cycles.
//  Capacity: 1 op in flight plus DEPTH queued. With res_ready=0, DEPTH+1 commands are accepted before cmd_ready falls.
//  Widths: no arithmetic on data; cnt is clog2(SETTLE+1) bits; FIFO count is clog2(DEPTH)+1 bits.
//  Reset mid-operation: outputs and FIFO clear immediately. A command or result in flight is discarded, never emitted.
// STRUCTURE
//  Shared package alu_issuer_pkg:
//  - Op-word field positions: SEL_MSB=7, SEL_LSB=5, A_MSB=4, A_LSB=2, B_MSB=1, B_LSB=0.
//  - FSM state encoding localparams.
//  - The sel opcode constants, shared with the ALU wrapper.
//  Sub-module alu_cmd_fifo:
//  - Generic DEPTHx8 synchronous FIFO with async reset.
//  - Exposes full/empty/push/pop.
//  Top: FSM, settle counter, and result/tag registers.
// TESTING
//  Bench ALU stub: alu_result = op_word ^ 8'hA5 (combinational). Defaults DEPTH=4, SETTLE=1.
//  1. Reset: rst=1 mid-sim -> all outputs 0 same cycle; cmd_ready=1 one edge after release.
//  2. Single op sel=0,a=5,b=3 -> op_word=8'h17 one edge after accept; res_valid two edges after accept; res_data=8'hB2; res_tag=0.
//  3. Backpressure: res_ready=0, cmd_valid held with 6 distinct ops -> exactly 5 accepted, then cmd_ready=0. Release res_ready -> results emitted in order with matching tags, none lost or duplicated.
//  4. Streaming: res_ready=1, 8 ops back-to-back -> one res_valid pulse every 2 cycles; op_word never changes while in WAIT. Repeat with SETTLE=3 -> every 4 cycles.
//  5. Reset mid-op: assert rst while in WAIT with 2 queued -> no res_valid after release; busy=0; FIFO empty.
//  6. Wrap: 3xDEPTH ops with random res_ready -> scoreboard matches every res_data/res_tag. FIFO pointers wrap without corruption.

Source files
------------

// File: rtl/alu_issuer_pkg.sv
// rtl/alu_issuer_pkg.sv - shared op-word layout, FSM states and ALU opcodes
package alu_issuer_pkg;

  localparam int SEL_MSB = 7;
  localparam int SEL_LSB = 5;
  localparam int A_MSB   = 4;
  localparam int A_LSB   = 2;
  localparam int B_MSB   = 1;
  localparam int B_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Opcode values must match the ALU wrapper's decode.
  localparam logic [2:0] SEL_ADD  = 3'd0;
  localparam logic [2:0] SEL_SUB  = 3'd1;
  localparam logic [2:0] SEL_AND  = 3'd2;
  localparam logic [2:0] SEL_OR   = 3'd3;
  localparam logic [2:0] SEL_XOR  = 3'd4;
  localparam logic [2:0] SEL_SHL  = 3'd5;
  localparam logic [2:0] SEL_SHR  = 3'd6;
  localparam logic [2:0] SEL_PASS = 3'd7;

  function automatic logic [7:0] pack_op(input logic [2:0] sel, input logic [2:0] a,
                                         input logic [1:0] b);
    return {sel, a, b};
  endfunction

endpackage

// File: rtl/alu_op_issuer_if.sv
// rtl/alu_op_issuer_if.sv - command, ALU byte and result signals of the issuer
interface alu_op_issuer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_sel;
  logic [2:0] cmd_a;
  logic [1:0] cmd_b;
  logic [7:0] op_word;
  logic [7:0] alu_result;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [2:0] res_tag;
  logic       busy;

  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, alu_result, res_ready,
    input  cmd_ready, op_word, res_valid, res_data, res_tag, busy
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, alu_result, res_ready,
    output cmd_ready, op_word, res_valid, res_data, res_tag, busy
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - DEPTHxWIDTH synchronous command FIFO, no bypass
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Full is judged on registered count, so a same-cycle pop never frees a slot.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/alu_op_issuer.sv
// rtl/alu_op_issuer.sv - queues ALU ops, drives the op byte, returns tagged results
module alu_op_issuer
  import alu_issuer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input logic            clk,
  input logic            rst,
  alu_op_issuer_if.slave bus
);
  localparam int CW = $clog2(SETTLE + 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    op_word, op_word_n;
  logic [2:0]    tag, tag_n;
  logic [7:0]    res_data, res_data_n;
  logic [2:0]    res_tag, res_tag_n;
  logic          res_valid, res_valid_n;
  logic          ready_en;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;

  assign fifo_push = bus.cmd_valid && bus.cmd_ready;

  alu_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (pack_op(bus.cmd_sel, bus.cmd_a, bus.cmd_b)),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    op_word_n   = op_word;
    tag_n       = tag;
    res_data_n  = res_data;
    res_tag_n   = res_tag;
    res_valid_n = res_valid;
    fifo_pop    = 1'b0;
    case (state)
      ST_IDLE: fifo_pop = !fifo_empty;
      ST_WAIT: begin
        if (cnt == '0) begin
          res_data_n  = bus.alu_result;
          res_tag_n   = tag;
          res_valid_n = 1'b1;
          state_n     = ST_HOLD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.res_ready) begin
          res_valid_n = 1'b0;
          state_n     = ST_IDLE;
          fifo_pop    = !fifo_empty;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // A pop always launches the next op, whether from IDLE or straight out of HOLD.
    if (fifo_pop) begin
      op_word_n = fifo_rdata;
      tag_n     = fifo_rdata[SEL_MSB:SEL_LSB];
      cnt_n     = CW'(SETTLE - 1);
      state_n   = ST_WAIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_word   <= '0;
      tag       <= '0;
      res_data  <= '0;
      res_tag   <= '0;
      res_valid <= 1'b0;
      ready_en  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      op_word   <= op_word_n;
      tag       <= tag_n;
      res_data  <= res_data_n;
      res_tag   <= res_tag_n;
      res_valid <= res_valid_n;
      ready_en  <= 1'b1;
    end
  end

  // ready_en keeps cmd_ready low through reset and until the first edge after release.
  assign bus.cmd_ready = ready_en && !fifo_full;
  assign bus.busy      = (state != ST_IDLE) || !fifo_empty;
  assign bus.op_word   = op_word;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data;
  assign bus.res_tag   = res_tag;
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb/tb_alu_op_issuer.sv - self-checking bench for alu_op_issuer (SETTLE=1 and SETTLE=3)
module tb_alu_op_issuer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_op_issuer_if b0 ();
  alu_op_issuer_if b1 ();
  assign b0.alu_result = b0.op_word ^ 8'hA5;
  assign b1.alu_result = b1.op_word ^ 8'hA5;

  alu_op_issuer #(.DEPTH(DEPTH), .SETTLE(1)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  alu_op_issuer #(.DEPTH(DEPTH), .SETTLE(3)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pack(input logic [2:0] s, input logic [2:0] a, input logic [1:0] b);
    return {s, a, b};
  endfunction

  function automatic logic [7:0] op_of(input int i);
    return pack(3'(i % 8), 3'((i * 3 + 1) % 8), 2'((i / 2) % 4));
  endfunction

  // Model: every accepted command owes exactly one result, in order: {tag, op word}.
  logic [10:0] q0[$];
  logic [10:0] q1[$];
  int          since_rst = 0;
  int          n_res0 = 0;
  int          n_res1 = 0;
  bit          h0 = 0, h1 = 0;
  logic [10:0] hd0, hd1;

  always @(negedge clk) begin
    if (rst) begin
      q0.delete(); q1.delete();
      since_rst = 0; h0 = 0; h1 = 0;
    end else begin
      since_rst++;
      if (since_rst == 1) begin
        chk("ready0_post_rst", b0.cmd_ready, 0);
        chk("ready1_post_rst", b1.cmd_ready, 0);
      end else begin
        chk("ready0", b0.cmd_ready, q0.size() < DEPTH + 1);
        chk("ready1", b1.cmd_ready, q1.size() < DEPTH + 1);
      end
      chk("busy0", b0.busy, q0.size() != 0);
      chk("busy1", b1.busy, q1.size() != 0);
      if (h0) begin
        chk("hold0_valid", b0.res_valid, 1);
        chk("hold0_stable", {b0.res_tag, b0.res_data}, hd0);
      end
      if (h1) begin
        chk("hold1_valid", b1.res_valid, 1);
        chk("hold1_stable", {b1.res_tag, b1.res_data}, hd1);
      end
      if (b0.res_valid) begin
        chk("res0_owed", q0.size() != 0, 1);
        if (q0.size() != 0) begin
          chk("res0_data", b0.res_data, q0[0][7:0] ^ 8'hA5);
          chk("res0_tag", b0.res_tag, q0[0][10:8]);
          chk("res0_op_word", b0.op_word, q0[0][7:0]);
          if (b0.res_ready) begin void'(q0.pop_front()); n_res0++; end
        end
      end
      if (b1.res_valid) begin
        chk("res1_owed", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          chk("res1_data", b1.res_data, q1[0][7:0] ^ 8'hA5);
          chk("res1_tag", b1.res_tag, q1[0][10:8]);
          chk("res1_op_word", b1.op_word, q1[0][7:0]);
          if (b1.res_ready) begin void'(q1.pop_front()); n_res1++; end
        end
      end
      h0 = b0.res_valid && !b0.res_ready; hd0 = {b0.res_tag, b0.res_data};
      h1 = b1.res_valid && !b1.res_ready; hd1 = {b1.res_tag, b1.res_data};
      if (b0.cmd_valid && b0.cmd_ready) q0.push_back({b0.cmd_sel, b0.cmd_sel, b0.cmd_a, b0.cmd_b});
      if (b1.cmd_valid && b1.cmd_ready) q1.push_back({b1.cmd_sel, b1.cmd_sel, b1.cmd_a, b1.cmd_b});
    end
  end

  task automatic set_cmd(input int w, input logic v, input logic [7:0] word);
    if (w == 0) begin
      b0.cmd_valid = v; b0.cmd_sel = word[7:5]; b0.cmd_a = word[4:2]; b0.cmd_b = word[1:0];
    end else begin
      b1.cmd_valid = v; b1.cmd_sel = word[7:5]; b1.cmd_a = word[4:2]; b1.cmd_b = word[1:0];
    end
  endtask

  task automatic set_rr(input int w, input logic v);
    if (w == 0) b0.res_ready = v; else b1.res_ready = v;
  endtask

  function automatic logic rdy(input int w); return (w == 0) ? b0.cmd_ready : b1.cmd_ready; endfunction
  function automatic logic rv(input int w);  return (w == 0) ? b0.res_valid : b1.res_valid; endfunction
  function automatic logic bsy(input int w); return (w == 0) ? b0.busy : b1.busy; endfunction

  task automatic chk_zero(input int w, input string tag);
    if (w == 0) chk({tag, "_outs0"}, {b0.op_word, b0.res_data, b0.res_tag, b0.res_valid, b0.cmd_ready, b0.busy}, 0);
    else        chk({tag, "_outs1"}, {b1.op_word, b1.res_data, b1.res_tag, b1.res_valid, b1.cmd_ready, b1.busy}, 0);
  endtask

  int         npulse;
  int         pt[16];
  logic [7:0] hist[96];

  // rr: 0 hold res_ready low, 1 hold high, 2 random each cycle.
  task automatic feed(input int w, input int n, input int base, input int rr, input int cycles,
                      output int acc);
    bit pend;
    int idx;
    pend = 0; idx = 0; npulse = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (pend) idx++;
      hist[c] = (w == 0) ? b0.op_word : b1.op_word;
      if (rv(w) && npulse < 16) begin pt[npulse] = c; npulse++; end
      set_rr(w, (rr == 2) ? ($urandom_range(0, 1) == 1) : (rr == 1));
      set_cmd(w, idx < n, op_of(base + idx));
      pend = (idx < n) && rdy(w);
    end
    @(posedge clk); #1;
    if (pend) idx++;
    set_cmd(w, 0, 8'h00);
    acc = idx;
  endtask

  task automatic drain(input int w, input int budget);
    set_rr(w, 1);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (!bsy(w)) break;
    end
  endtask

  initial begin
    int acc, base_res, cnt_rv;
    set_cmd(0, 0, 8'h00); set_cmd(1, 0, 8'h00);
    set_rr(0, 0); set_rr(1, 1);

    chk("pin_pack_a", pack(3'd0, 3'd5, 2'd3), 8'h17);
    chk("pin_pack_b", pack(3'd7, 3'd7, 2'd3), 8'hFF);
    chk("pin_stub", pack(3'd3, 3'd2, 2'd1) ^ 8'hA5, 8'hCC);

    repeat (2) @(posedge clk);
    #1;
    chk_zero(0, "init"); chk_zero(1, "init");
    rst = 0;
    @(posedge clk); #1;
    chk("init_ready0", b0.cmd_ready, 1);

    // single op latency
    set_cmd(0, 1, pack(3'd0, 3'd5, 2'd3));
    @(posedge clk); #1;
    set_cmd(0, 0, 8'h00);
    chk("single_op_before", b0.op_word, 8'h00);
    @(posedge clk); #1;
    chk("single_op_word", b0.op_word, 8'h17);
    chk("single_rv_early", b0.res_valid, 0);
    @(posedge clk); #1;
    chk("single_rv", b0.res_valid, 1);
    chk("single_data", b0.res_data, 8'hB2);
    chk("single_tag", b0.res_tag, 0);
    set_rr(0, 1);
    @(posedge clk); #1;
    chk("single_rv_done", b0.res_valid, 0);
    set_rr(0, 0);

    // asynchronous reset mid-sim
    #2 rst = 1;
    #1 chk_zero(0, "midrst"); chk_zero(1, "midrst");
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_ready_low", b0.cmd_ready, 0);
    @(posedge clk); #1;
    chk("midrst_ready0", b0.cmd_ready, 1);
    chk("midrst_ready1", b1.cmd_ready, 1);

    // backpressure: 6 offered, DEPTH+1 accepted
    base_res = n_res0;
    feed(0, 6, 1, 0, 10, acc);
    chk("bp_accepted", acc, DEPTH + 1);
    chk("bp_ready_low", b0.cmd_ready, 0);
    drain(0, 40);
    chk("bp_drained", b0.busy, 0);
    chk("bp_results", n_res0 - base_res, DEPTH + 1);
    chk("bp_queue_empty", q0.size(), 0);

    // streaming, SETTLE=1
    feed(0, 8, 2, 1, 40, acc);
    chk("s1_accepted", acc, 8);
    chk("s1_pulses", npulse, 8);
    for (int k = 0; k < 7; k++) chk("s1_period", pt[k+1] - pt[k], 2);

    // streaming, SETTLE=3, op_word stable through WAIT
    feed(1, 8, 3, 1, 48, acc);
    chk("s3_accepted", acc, 8);
    chk("s3_pulses", npulse, 8);
    for (int k = 0; k < 7; k++) chk("s3_period", pt[k+1] - pt[k], 4);
    for (int k = 1; k < 8; k++) begin
      for (int d = 1; d <= 3; d++) chk("s3_op_stable", hist[pt[k]-d], hist[pt[k]]);
      chk("s3_op_changed", hist[pt[k]-4] != hist[pt[k]], 1);
    end

    // reset while WAIT with two queued
    feed(1, 3, 40, 0, 3, acc);
    chk("mr_accepted", acc, 3);
    chk("mr_in_wait", {b1.busy, b1.res_valid}, 2'b10);
    #2 rst = 1;
    #1 chk_zero(1, "mr");
    set_rr(1, 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    base_res = n_res1;
    cnt_rv = 0;
    repeat (10) begin
      @(posedge clk); #1;
      cnt_rv += int'(b1.res_valid);
    end
    chk("mr_no_result", cnt_rv, 0);
    chk("mr_no_handshake", n_res1 - base_res, 0);
    chk("mr_busy", b1.busy, 0);
    chk("mr_ready", b1.cmd_ready, 1);

    // pointer wrap with random backpressure
    base_res = n_res0;
    feed(0, 3 * DEPTH, 6, 2, 80, acc);
    chk("wrap_accepted", acc, 3 * DEPTH);
    drain(0, 60);
    chk("wrap_drained", b0.busy, 0);
    chk("wrap_results", n_res0 - base_res, 3 * DEPTH);
    chk("wrap_queue_empty", q0.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end
endmodule
